// File: rtl/ifa_bus_arbiter.sv
// Round-robin arbiter and transaction sequencer for the shared ifa memory bus.
// One master at a time owns the bus; memory answers with bus_rdy or the access is timed out.
module ifa_bus_arbiter #(
  parameter int NREQ    = 2,
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     m_req,
  output logic [NREQ-1:0]     m_gnt,
  input  logic [NREQ-1:0]     m_start,
  input  logic [2*NREQ-1:0]   m_mode,
  input  logic [AW*NREQ-1:0]  m_addr,
  input  logic [DW*NREQ-1:0]  m_wdata,
  output logic [NREQ-1:0]     m_rdy,
  output logic                m_err,
  output logic [DW-1:0]       m_rdata,
  output logic                bus_start,
  output logic [1:0]          bus_mode,
  output logic [AW-1:0]       bus_addr,
  output logic [DW-1:0]       bus_wdata,
  input  logic                bus_rdy,
  input  logic [DW-1:0]       bus_rdata,
  output logic                busy
);

  localparam int IW = (NREQ > 2) ? 2 : 1;
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);
  localparam logic [IW-1:0]   LAST_RST = IW'(NREQ - 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]      r_state;
  logic [IW-1:0]   r_win;
  logic [IW-1:0]   r_last;
  logic [CW-1:0]   r_cnt;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_rdy;
  logic            r_err;
  logic [DW-1:0]   r_rdata;
  logic            r_bus_start;
  logic [1:0]      r_bus_mode;
  logic [AW-1:0]   r_bus_addr;
  logic [DW-1:0]   r_bus_wdata;
  logic            r_busy;

  logic            w_any;
  logic [IW-1:0]   w_pick;
  logic [IW-1:0]   w_idx;

  // Search downward so the candidate just after r_last is written last and wins.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_idx  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = IW'((int'(r_last) + k) % NREQ);
      if (m_req[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_win       <= '0;
      r_last      <= LAST_RST;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_rdy       <= '0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_bus_start <= 1'b0;
      r_bus_mode  <= '0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_bus_start <= 1'b0;
      r_rdy       <= '0;
      r_err       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_win   <= w_pick;
            r_gnt   <= ONE_HOT0 << w_pick;
            r_busy  <= 1'b1;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!m_req[r_win]) begin
            r_gnt   <= '0;
            r_last  <= r_win;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (m_start[r_win]) begin
            r_bus_start <= 1'b1;
            r_bus_mode  <= m_mode[int'(r_win)*2 +: 2];
            r_bus_addr  <= m_addr[int'(r_win)*AW +: AW];
            r_bus_wdata <= m_wdata[int'(r_win)*DW +: DW];
            r_cnt       <= '0;
            r_state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_cnt <= r_cnt + CW'(1);
          // bus_rdy seen alongside our own start strobe belongs to nobody.
          if (bus_rdy && !r_bus_start) begin
            r_rdy   <= ONE_HOT0 << r_win;
            r_rdata <= bus_rdata;
            r_gnt   <= '0;
            r_last  <= r_win;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (r_cnt == CNT_LAST) begin
            r_rdy   <= ONE_HOT0 << r_win;
            r_err   <= 1'b1;
            r_rdata <= '0;
            r_gnt   <= '0;
            r_last  <= r_win;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_gnt     = r_gnt;
  assign m_rdy     = r_rdy;
  assign m_err     = r_err;
  assign m_rdata   = r_rdata;
  assign bus_start = r_bus_start;
  assign bus_mode  = r_bus_mode;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_ifa_bus_arbiter.sv
// Scoreboard bench for ifa_bus_arbiter: a transaction-level driver predicts grant, start and
// completion events into queues; a negedge monitor pops and compares whenever the DUT shows one.
module tb_ifa_bus_arbiter;

  localparam int NREQ    = 2;
  localparam int AW      = 8;
  localparam int DW      = 8;
  localparam int TIMEOUT = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     m_req;
  logic [NREQ-1:0]     m_gnt;
  logic [NREQ-1:0]     m_start;
  logic [2*NREQ-1:0]   m_mode;
  logic [AW*NREQ-1:0]  m_addr;
  logic [DW*NREQ-1:0]  m_wdata;
  logic [NREQ-1:0]     m_rdy;
  logic                m_err;
  logic [DW-1:0]       m_rdata;
  logic                bus_start;
  logic [1:0]          bus_mode;
  logic [AW-1:0]       bus_addr;
  logic [DW-1:0]       bus_wdata;
  logic                bus_rdy;
  logic [DW-1:0]       bus_rdata;
  logic                busy;

  ifa_bus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req(m_req), .m_gnt(m_gnt), .m_start(m_start), .m_mode(m_mode),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rdy(m_rdy), .m_err(m_err), .m_rdata(m_rdata),
    .bus_start(bus_start), .bus_mode(bus_mode), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdy(bus_rdy), .bus_rdata(bus_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int cyc; logic [NREQ-1:0] gnt; logic busy; } gnt_ev_t;
  typedef struct { int cyc; logic [1:0] mode; logic [AW-1:0] addr; logic [DW-1:0] wdata; } start_ev_t;
  typedef struct { int cyc; logic [NREQ-1:0] rdy; logic err; logic [DW-1:0] rdata; } rdy_ev_t;

  gnt_ev_t   gnt_q[$];
  start_ev_t start_q[$];
  rdy_ev_t   rdy_q[$];

  int last_w;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none cycle=%0d", name, cyc);
  endtask

  task automatic push_gnt(input int c, input logic [NREQ-1:0] g, input logic b);
    gnt_ev_t e;
    e.cyc = c; e.gnt = g; e.busy = b;
    gnt_q.push_back(e);
  endtask

  task automatic push_rdy(input int c, input logic [NREQ-1:0] r, input logic e_err, input logic [DW-1:0] d);
    rdy_ev_t e;
    e.cyc = c; e.rdy = r; e.err = e_err; e.rdata = d;
    rdy_q.push_back(e);
  endtask

  // Monitor: one pop per observed event, plus bus-field stability while an access is open.
  logic [NREQ-1:0] prev_gnt;
  logic            prev_busy;
  bit              in_acc = 1'b0;
  start_ev_t       cur;

  always @(negedge clk) begin
    if (mon_en) begin
      gnt_ev_t   ge;
      start_ev_t se;
      rdy_ev_t   re;
      if (m_gnt !== prev_gnt || busy !== prev_busy) begin
        if (gnt_q.size() == 0) unexpected("gnt_change");
        else begin
          ge = gnt_q.pop_front();
          chk("gnt_cycle", 64'(cyc), 64'(ge.cyc));
          chk("gnt_value", 64'(m_gnt), 64'(ge.gnt));
          chk("busy", 64'(busy), 64'(ge.busy));
        end
        prev_gnt  = m_gnt;
        prev_busy = busy;
        if (m_gnt == '0) in_acc = 1'b0;
      end
      if (bus_start === 1'b1) begin
        if (start_q.size() == 0) unexpected("bus_start");
        else begin
          se = start_q.pop_front();
          chk("start_cycle", 64'(cyc), 64'(se.cyc));
          chk("bus_mode", 64'(bus_mode), 64'(se.mode));
          chk("bus_addr", 64'(bus_addr), 64'(se.addr));
          chk("bus_wdata", 64'(bus_wdata), 64'(se.wdata));
          cur    = se;
          in_acc = 1'b1;
        end
      end else if (bus_start !== 1'b0) begin
        unexpected("bus_start_x");
      end else if (in_acc) begin
        chk("mode_stable", 64'(bus_mode), 64'(cur.mode));
        chk("addr_stable", 64'(bus_addr), 64'(cur.addr));
        chk("wdata_stable", 64'(bus_wdata), 64'(cur.wdata));
      end
      if (m_rdy !== '0 || m_err !== 1'b0) begin
        if (rdy_q.size() == 0) unexpected("m_rdy");
        else begin
          re = rdy_q.pop_front();
          chk("rdy_cycle", 64'(cyc), 64'(re.cyc));
          chk("m_rdy", 64'(m_rdy), 64'(re.rdy));
          chk("m_err", 64'(m_err), 64'(re.err));
          chk("m_rdata", 64'(m_rdata), 64'(re.rdata));
          $display("txn cycle=%0d rdy=%b err=%b rdata=%h", cyc, m_rdy, m_err, m_rdata);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    m_start   = NREQ'($urandom);
    m_mode    = (2*NREQ)'($urandom);
    m_addr    = (AW*NREQ)'($urandom);
    m_wdata   = (DW*NREQ)'($urandom);
    bus_rdy   = 1'($urandom);
    bus_rdata = DW'($urandom);
  endtask

  task automatic reset_checks();
    chk("rst_gnt", 64'(m_gnt), 64'(0));
    chk("rst_rdy", 64'(m_rdy), 64'(0));
    chk("rst_err", 64'(m_err), 64'(0));
    chk("rst_rdata", 64'(m_rdata), 64'(0));
    chk("rst_bus_start", 64'(bus_start), 64'(0));
    chk("rst_bus_mode", 64'(bus_mode), 64'(0));
    chk("rst_bus_addr", 64'(bus_addr), 64'(0));
    chk("rst_bus_wdata", 64'(bus_wdata), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
  endtask

  // One arbitration round from IDLE. lat: cycle in ACCESS (1..TIMEOUT-1) bus_rdy is given, 0 = never.
  // rst_k: ACCESS cycle at which reset is pulsed, 0 = no reset.
  task automatic run_episode(input logic [NREQ-1:0] mask, input int hold, input bit withdraw,
                             input int lat, input int rst_k, input bit fixed,
                             input logic [1:0] f_mode, input logic [AW-1:0] f_addr,
                             input logic [DW-1:0] f_wdata, input logic [DW-1:0] f_rdata);
    int w;
    logic [NREQ-1:0] oh;
    start_ev_t se;
    rand_inputs();
    m_req = mask;
    if (mask == '0) begin
      tick();
      return;
    end
    w = -1;
    for (int k = 1; k <= NREQ; k++)
      if (w < 0 && mask[(last_w + k) % NREQ]) w = (last_w + k) % NREQ;
    oh = '0;
    oh[w] = 1'b1;
    push_gnt(cyc + 1, oh, 1'b1);
    tick();
    for (int h = 0; h < hold; h++) begin
      rand_inputs();
      m_start[w] = 1'b0;
      tick();
    end
    rand_inputs();
    if (withdraw) begin
      m_req[w] = 1'b0;
      push_gnt(cyc + 1, '0, 1'b0);
      tick();
      last_w = w;
      return;
    end
    m_start[w] = 1'b1;
    if (fixed) begin
      m_mode[2*w +: 2]   = f_mode;
      m_addr[AW*w +: AW] = f_addr;
      m_wdata[DW*w +: DW] = f_wdata;
    end
    se.cyc   = cyc + 1;
    se.mode  = m_mode[2*w +: 2];
    se.addr  = m_addr[AW*w +: AW];
    se.wdata = m_wdata[DW*w +: DW];
    start_q.push_back(se);
    tick();
    rand_inputs();  // inputs sampled in the bus_start cycle, bus_rdy included, have no effect
    tick();
    for (int k = 1; k < TIMEOUT; k++) begin
      rand_inputs();
      bus_rdy = 1'b0;
      if (k == rst_k) begin
        rst_n = 1'b0;
        push_gnt(cyc + 1, '0, 1'b0);
        tick();
        rst_n = 1'b1;
        last_w = NREQ - 1;
        reset_checks();
        return;
      end
      if (k == lat) begin
        bus_rdy = 1'b1;
        if (fixed) bus_rdata = f_rdata;
        push_rdy(cyc + 1, oh, 1'b0, bus_rdata);
        push_gnt(cyc + 1, '0, 1'b0);
        tick();
        break;
      end
      if (k == TIMEOUT - 1) begin
        push_rdy(cyc + 1, oh, 1'b1, '0);
        push_gnt(cyc + 1, '0, 1'b0);
        tick();
        break;
      end
      tick();
    end
    last_w = w;
  endtask

  initial begin
    int r, lat;
    rst_n = 1'b0;
    m_req = '0;
    rand_inputs();
    tick();
    tick();
    reset_checks();
    prev_gnt  = '0;
    prev_busy = 1'b0;
    last_w    = NREQ - 1;
    mon_en    = 1'b1;
    rst_n     = 1'b1;

    // single master, memory answers on the third ACCESS cycle
    run_episode(2'b01, 0, 1'b0, 3, 0, 1'b1, 2'b01, 8'h3C, 8'hA5, 8'h5A);
    // both masters requesting: grants alternate
    for (int i = 0; i < 4; i++)
      run_episode(2'b11, 0, 1'b0, 2, 0, 1'b1, 2'b00, 8'(8'h40 + i), 8'h00, 8'(8'h11 * (i + 1)));
    // master 1 withdraws, then master 0 wins
    run_episode(2'b11, 1, 1'b1, 2, 0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
    run_episode(2'b11, 0, 1'b0, 1, 0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
    // timeout, then rdy coinciding with the last counted cycle
    run_episode(2'b11, 0, 1'b0, 0, 0, 1'b0, 2'b10, 8'h00, 8'h00, 8'h00);
    run_episode(2'b11, 0, 1'b0, TIMEOUT - 1, 0, 1'b0, 2'b11, 8'h00, 8'h00, 8'h00);
    // idle cycles with stray bus_rdy and m_start
    for (int i = 0; i < 3; i++) run_episode(2'b00, 0, 1'b0, 0, 0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
    // reset in the middle of an access; master 0 has priority afterwards
    run_episode(2'b11, 0, 1'b0, 0, 5, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
    run_episode(2'b11, 0, 1'b0, 2, 0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);

    for (int i = 0; i < 250; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) lat = 0;
      else if (r == 1) lat = TIMEOUT - 1;
      else lat = int'($urandom_range(1, 6));
      run_episode(NREQ'($urandom_range(0, (1 << NREQ) - 1)), int'($urandom_range(0, 2)),
                  ($urandom_range(0, 4) == 0), lat,
                  (($urandom_range(0, 29) == 0) ? int'($urandom_range(1, TIMEOUT - 1)) : 0),
                  1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
    end

    m_req = '0;
    repeat (3) tick();
    chk("gnt_q_empty", 64'(gnt_q.size()), 64'(0));
    chk("start_q_empty", 64'(start_q.size()), 64'(0));
    chk("rdy_q_empty", 64'(rdy_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ifa_bus_arbiter.md
Name: ifa_bus_arbiter

Overview:
- Round-robin arbiter and transaction sequencer for the shared `ifa` bus.
- Several bus masters (CPU core, DMA, debug) share the single memory port through it.
- It owns the req/gnt handshake, drives start/mode/addr/data to the memory side for the granted master, waits for rdy, and returns rdy/read data to that master.
- A timeout counter frees the bus if memory never answers.

Parameters:
- NREQ, 2, number of requesters (2..4).
- AW, 8, address width; matches `ifa` addr.
- DW, 8, data width; matches `ifa` data.
- TIMEOUT, 16, cycles in ACCESS without bus_rdy before abort (>=2).

Ports:
- clk  input  1  bus clock, same clock as `ifa`.
- rst_n  input  1  synchronous active-low reset.
- m_req  input  NREQ  per-master bus request, level.
- m_gnt  output  NREQ  per-master grant, one-hot or zero.
- m_start  input  NREQ  per-master transaction start, honoured only from the granted master.
- m_mode  input  2*NREQ  per-master mode, slice i = [2i+1:2i].
- m_addr  input  AW*NREQ  per-master address.
- m_wdata  input  DW*NREQ  per-master write data.
- m_rdy  output  NREQ  one-cycle completion pulse to the granted master.
- m_err  output  1  one-cycle pulse, coincident with m_rdy, on timeout.
- m_rdata  output  DW  read data, valid only in the m_rdy cycle.
- bus_start  output  1  one-cycle start strobe to memory.
- bus_mode  output  2  registered mode, stable through ACCESS.
- bus_addr  output  AW  registered address, stable through ACCESS.
- bus_wdata  output  DW  registered write data, stable through ACCESS.
- bus_rdy  input  1  memory completion.
- bus_rdata  input  DW  memory read data, sampled when bus_rdy=1.
- busy  output  1  high in GRANT or ACCESS.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low (rst_n). All outputs are registered.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; m_gnt, m_rdy, m_err, bus_start and busy = 0; bus_mode, bus_addr, bus_wdata, m_rdata = 0; timeout counter = 0.
  - last_winner = NREQ-1, so master 0 wins first.
  - Reset mid-transaction aborts silently: no m_rdy, no m_err.
- IDLE:
  - m_gnt=0.
  - If any m_req is sampled high, the winner is the first requester searched from last_winner+1 with wrap modulo NREQ. The next cycle has m_gnt[w]=1 and state=GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - m_gnt[w] held.
  - If m_req[w]=0 is sampled: m_gnt drops next cycle, last_winner=w, state=IDLE, no bus activity.
  - Else, if m_start[w]=1 is sampled: next cycle bus_start=1 (exactly one cycle), bus_mode/addr/wdata capture slice w, counter=0, state=ACCESS.
  - m_start from non-granted masters is ignored in every state.
- ACCESS:
  - m_gnt[w] held; counter increments each cycle.
  - If bus_rdy=1 is sampled: next cycle m_rdy[w]=1, m_rdata=bus_rdata, m_gnt=0, last_winner=w, state=IDLE.
  - If counter reaches TIMEOUT-1 with bus_rdy=0: next cycle m_rdy[w]=1, m_err=1, m_rdata=0, m_gnt=0, last_winner=w, state=IDLE.
  - If bus_rdy and timeout occur in the same cycle, rdy wins and m_err=0.
  - bus_rdy is ignored outside ACCESS, including when bus_rdy=1 in the same cycle as bus_start.
- Latency:
  - Request to grant is 1 cycle.
  - Grant/start sample to bus_start is 1 cycle.
  - bus_rdy to m_rdy is 1 cycle.
  - After every release there is at least one cycle with m_gnt all zero (IDLE) before the next grant.
- The arbiter never changes mode/addr/data mid-ACCESS. Mode is passed through opaquely.

Test Plan:
- Single master: m_req[0]=1 at cycle 0, m_start[0] with addr=8'h3C, mode=2'b01, wdata=8'hA5; memory returns bus_rdy after 3 cycles -> m_gnt[0] at cycle 1, one-cycle bus_start with bus_addr=3C, bus_wdata=A5, m_rdy[0] one cycle after bus_rdy, m_err=0.
- Round-robin: m_req=2'b11 held, each master issuing back-to-back reads -> grants alternate 0,1,0,1 with an all-zero m_gnt cycle between them. m_rdata returns the bus_rdata values (8'h11, 8'h22, ...) to the correct master.
- Withdrawn request: master 1 granted, drops m_req before m_start -> m_gnt returns to 0 next cycle, no bus_start, and master 0 is granted next if requesting.
- Timeout: TIMEOUT=16, bus_rdy held low -> m_rdy and m_err pulse together 16 cycles after bus_start, bus freed, next requester granted.
- Ignored inputs: m_start[1]=1 while master 0 granted, and bus_rdy=1 in IDLE -> no bus_start for master 1, no m_rdy.
- Reset mid-ACCESS: rst_n=0 for one cycle -> all outputs 0 next cycle, no m_rdy/m_err; after release, master 0 has priority.
